fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter in front of the FIFO memory/write-pointer side.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared types and helpers for the FIFO write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Round-robin successor of ptr, wrapping to 0 after nreq-1.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned nreq);
        return ((ptr + 1) >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-priority picker, first set bit from rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] w_j;

    // Scan highest offset first so the lowest offset from rr_ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = IDW'((32'(rr_ptr) + 32'(k)) % 32'(NREQ));
            if (req[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Burst-locked round-robin arbiter sharing one FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int c_IDW = $clog2(NREQ);
    localparam int c_BCW = $clog2(MAX_BURST + 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [c_IDW-1:0]    r_owner;
    logic [c_IDW-1:0]    r_rr_ptr;
    logic [c_BCW-1:0]    r_beat_cnt;
    logic                w_found;
    logic [c_IDW-1:0]    w_pick;
    logic [DATASIZE-1:0] w_lane;
    logic                w_beat;
    logic                w_end;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (c_IDW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick)
    );

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_IDW'(i)) begin
                w_lane = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    assign w_beat = (r_state == ARB_LOCK) && req_valid[r_owner] && !wfull;
    assign w_end  = w_beat && (req_last[r_owner] || (r_beat_cnt == c_BCW'(MAX_BURST - 1)));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: if (w_found) w_next_state = ARB_LOCK;
            ARB_LOCK: if (w_end)   w_next_state = ARB_IDLE;
            default:               w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        busy      = 1'b0;
        if (r_state == ARB_LOCK) begin
            req_ready[r_owner] = !wfull;
            winc               = w_beat;
            wdata              = w_lane;
            busy               = 1'b1;
        end
    end

    // Owner and pointer only move at grant and at end of burst.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (r_state == ARB_IDLE) begin
                if (w_found) begin
                    r_owner    <= w_pick;
                    r_beat_cnt <= '0;
                end
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + c_BCW'(1);
                if (w_end) begin
                    r_rr_ptr <= c_IDW'(next_rr(32'(r_owner), 32'(NREQ)));
                end
            end
        end
    end

    assign grant_id = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for the burst-locked FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .DATASIZE  (8),
        .NREQ      (4),
        .MAX_BURST (4)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int          errors = 0;
    int          checks = 0;
    logic [9:0]  sb[$];
    logic [10:0] lmem[4][32];
    int          head[4];
    int          tail[4];
    int          gap_left[4];
    logic [3:0]  acc = '0;
    int          cyc = 0;
    int          nbeats = 0;
    int          beat_cyc[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic put(input int lane, input logic [7:0] d, input logic last, input logic [1:0] gap);
        lmem[lane][tail[lane]] = {gap, last, d};
        tail[lane]++;
    endtask

    task automatic expect_w(input int id, input logic [7:0] d);
        sb.push_back({2'(id), d});
    endtask

    task automatic drain(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(posedge wclk);
            #2;
            n++;
            done = (sb.size() == 0) && !busy;
            for (int i = 0; i < 4; i++) if (head[i] < tail[i]) done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: %0d words still expected after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        do begin
            @(posedge wclk);
            #1;
            n++;
        end while (nbeats < target && n < 100);
    endtask

    // Requester models: present head word, advance on accepted handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0; tail[i] = 0; gap_left[i] = 0;
        end
        forever begin
            @(posedge wclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    head[i]++;
                    gap_left[i] = (head[i] < tail[i]) ? int'(lmem[i][head[i]][10:9]) : 0;
                end
                if (head[i] < tail[i] && gap_left[i] == 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*8 +: 8]   = lmem[i][head[i]][7:0];
                    req_last[i]          = lmem[i][head[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    if (gap_left[i] > 0) gap_left[i]--;
                end
            end
        end
    end

    // Monitor: every FIFO write pops the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge wclk);
            cyc++;
            acc = req_valid & req_ready;
            if (wfull) chk("winc_while_full", 32'(winc), 32'(0));
            if (winc) begin
                if (nbeats < 64) beat_cyc[nbeats] = cyc;
                nbeats++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got id=%0d data=%0h, none expected", grant_id, wdata);
                end else begin
                    e = sb.pop_front();
                    chk("write_id_data", {22'd0, grant_id, wdata}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        wfull  = 1'b0;
        wrst_n = 1'b0;
        repeat (2) @(negedge wclk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_winc", 32'(winc), 32'(0));
        chk("rst_gid", 32'(grant_id), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_wdata", 32'(wdata), 32'(0));
        @(posedge wclk); #3 wrst_n = 1'b1;

        // Single 3-word packet on requester 0
        @(posedge wclk); #2;
        put(0, 8'hA0, 1'b0, 2'd0); put(0, 8'hA1, 1'b0, 2'd0); put(0, 8'hA2, 1'b1, 2'd0);
        expect_w(0, 8'hA0); expect_w(0, 8'hA1); expect_w(0, 8'hA2);
        @(negedge wclk);
        @(negedge wclk);
        chk("t1_arb_winc", 32'(winc), 32'(0));
        chk("t1_arb_busy", 32'(busy), 32'(0));
        @(negedge wclk);
        chk("t1_lock_busy", 32'(busy), 32'(1));
        chk("t1_first_winc", 32'(winc), 32'(1));
        drain("t1");
        chk("t1_gid_hold", 32'(grant_id), 32'(0));

        // All four requesters with 1-word packets, from a fresh pointer
        @(posedge wclk); #3 wrst_n = 1'b0;
        @(posedge wclk); #3 wrst_n = 1'b1;
        @(posedge wclk); #2;
        base = nbeats;
        put(0, 8'hB0, 1'b1, 2'd0); put(1, 8'hB1, 1'b1, 2'd0);
        put(2, 8'hB2, 1'b1, 2'd0); put(3, 8'hB3, 1'b1, 2'd0);
        put(0, 8'hB4, 1'b1, 2'd0);
        expect_w(0, 8'hB0); expect_w(1, 8'hB1); expect_w(2, 8'hB2);
        expect_w(3, 8'hB3); expect_w(0, 8'hB4);
        drain("t2");
        for (int k = 1; k < 5; k++)
            chk("t2_grant_spacing", 32'(beat_cyc[base+k] - beat_cyc[base+k-1]), 32'(2));

        // Long stream on requester 2, others served between 4-word chunks
        @(posedge wclk); #2;
        for (int k = 0; k < 10; k++) put(2, 8'hC0 + 8'(k), (k == 9), 2'd0);
        put(3, 8'hD0, 1'b1, 2'd0); put(3, 8'hD1, 1'b1, 2'd0);
        put(0, 8'hE0, 1'b1, 2'd0); put(0, 8'hE1, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) expect_w(2, 8'hC0 + 8'(k));
        expect_w(3, 8'hD0); expect_w(0, 8'hE0);
        for (int k = 4; k < 8; k++) expect_w(2, 8'hC0 + 8'(k));
        expect_w(3, 8'hD1); expect_w(0, 8'hE1);
        expect_w(2, 8'hC8); expect_w(2, 8'hC9);
        drain("t3");

        // FIFO full for 3 cycles in the middle of a burst
        @(posedge wclk); #2;
        base = nbeats;
        for (int k = 0; k < 4; k++) begin
            put(1, 8'hF0 + 8'(k), (k == 3), 2'd0);
            expect_w(1, 8'hF0 + 8'(k));
        end
        wait_beats(base + 2);
        wfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            chk("t4_full_winc", 32'(winc), 32'(0));
            chk("t4_full_ready", 32'(req_ready), 32'(0));
            chk("t4_full_busy", 32'(busy), 32'(1));
        end
        @(posedge wclk); #1 wfull = 1'b0;
        drain("t4");

        // Owner pauses 2 cycles mid-packet while requester 1 waits
        @(posedge wclk); #2;
        base = nbeats;
        put(2, 8'h60, 1'b0, 2'd0); put(2, 8'h61, 1'b0, 2'd2); put(2, 8'h62, 1'b1, 2'd0);
        put(1, 8'h70, 1'b1, 2'd0);
        expect_w(2, 8'h60); expect_w(2, 8'h61); expect_w(2, 8'h62); expect_w(1, 8'h70);
        wait_beats(base + 1);
        @(negedge wclk);
        chk("t5_gap_busy", 32'(busy), 32'(1));
        chk("t5_gap_gid", 32'(grant_id), 32'(2));
        chk("t5_gap_ready", 32'(req_ready), 32'(4'b0100));
        chk("t5_gap_winc", 32'(winc), 32'(0));
        drain("t5");
        chk("t5_gap_len", 32'(beat_cyc[base+1] - beat_cyc[base]), 32'(3));

        // Reset mid-burst; arbitration restarts from requester 0
        @(posedge wclk); #2;
        base = nbeats;
        for (int k = 0; k < 4; k++) put(3, 8'h90 + 8'(k), (k == 3), 2'd0);
        put(0, 8'h80, 1'b1, 2'd0);
        expect_w(3, 8'h90); expect_w(3, 8'h91); expect_w(0, 8'h80);
        expect_w(3, 8'h92); expect_w(3, 8'h93);
        wait_beats(base + 2);
        #2 wrst_n = 1'b0;
        #1;
        chk("t6_rst_winc", 32'(winc), 32'(0));
        chk("t6_rst_ready", 32'(req_ready), 32'(0));
        chk("t6_rst_busy", 32'(busy), 32'(0));
        chk("t6_rst_gid", 32'(grant_id), 32'(0));
        @(posedge wclk); @(posedge wclk); #3 wrst_n = 1'b1;
        drain("t6");
        chk("t6_gid_hold", 32'(grant_id), 32'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
